// File: rtl/fixed_point_divider_if.sv
// Operand/result handshake bundle for the sign-magnitude fixed-point divider.
// The master side supplies operands and accepts results. The slave side is the divider.
interface fixed_point_divider_if #(
    parameter int W = 32
);
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         valid_in;
    logic         ready_out;
    logic [W-1:0] quotient_out;
    logic         overflow_out;
    logic         div_by_zero_out;
    logic         valid_out;
    logic         ready_in;

    modport master (
        output a_in, b_in, valid_in, ready_in,
        input  ready_out, quotient_out, overflow_out, div_by_zero_out, valid_out
    );

    modport slave (
        input  a_in, b_in, valid_in, ready_in,
        output ready_out, quotient_out, overflow_out, div_by_zero_out, valid_out
    );
endinterface

// File: rtl/fixed_point_divider.sv
// Sequential sign-magnitude fixed-point divider using restoring shift-subtract.
// It produces one quotient bit per clock, and only one division is in flight at a time.
module fixed_point_divider #(
    parameter int sign = 1,
    parameter int q_m  = 16,
    parameter int q_n  = 15
) (
    input logic                  clk_in,
    input logic                  rst_n_in,
    fixed_point_divider_if.slave div_if
);
    localparam int W  = sign + q_m + q_n;
    localparam int M  = W - 1;
    localparam int N  = M + q_n;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    dividend;
    logic [M:0]      remainder;
    logic [N-1:0]    quotient;
    logic [M-1:0]    b_mag;
    logic            sign_q;
    logic [CW-1:0]   counter;
    logic [W-1:0]    quotient_reg;
    logic            overflow_reg;
    logic            dbz_reg;

    logic            accept;
    logic [M-1:0]    a_mag_in;
    logic [M-1:0]    b_mag_in;
    logic            b_zero_in;
    logic [M:0]      trial;
    logic            trial_ge;
    logic [M:0]      rem_step;
    logic [N-1:0]    quot_step;
    logic [W:0]      result_step;

    // Saturate the N-bit quotient to an M-bit magnitude and suppress negative zero.
    function automatic logic [W:0] form_result(input logic [N-1:0] q, input logic sgn);
        logic         ovf;
        logic [M-1:0] mag;
        ovf = |q[N-1:M];
        mag = ovf ? {M{1'b1}} : q[M-1:0];
        return {ovf, sgn && (mag != '0), mag};
    endfunction

    assign a_mag_in  = div_if.a_in[M-1:0];
    assign b_mag_in  = div_if.b_in[M-1:0];
    assign b_zero_in = (b_mag_in == '0);

    // After each step the remainder stays below b_mag, so it fits in M bits before the shift.
    assign trial       = {remainder[M-1:0], dividend[N-1]};
    assign trial_ge    = (trial >= {1'b0, b_mag});
    assign rem_step    = trial_ge ? (trial - {1'b0, b_mag}) : trial;
    assign quot_step   = {quotient[N-2:0], trial_ge};
    assign result_step = form_result(quot_step, sign_q);

    always_comb begin
        state_next       = state;
        div_if.ready_out = 1'b0;
        div_if.valid_out = 1'b0;
        accept           = 1'b0;
        case (state)
            IDLE: begin
                div_if.ready_out = 1'b1;
                accept           = div_if.valid_in;
                if (div_if.valid_in)
                    state_next = b_zero_in ? DONE : DIVIDE;
            end
            DIVIDE: begin
                if (counter == '0)
                    state_next = DONE;
            end
            DONE: begin
                div_if.valid_out = 1'b1;
                if (div_if.ready_in)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            dividend     <= '0;
            remainder    <= '0;
            quotient     <= '0;
            b_mag        <= '0;
            sign_q       <= 1'b0;
            counter      <= '0;
            quotient_reg <= '0;
            overflow_reg <= 1'b0;
            dbz_reg      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dividend  <= {a_mag_in, {q_n{1'b0}}};
                        remainder <= '0;
                        quotient  <= '0;
                        b_mag     <= b_mag_in;
                        sign_q    <= div_if.a_in[W-1] ^ div_if.b_in[W-1];
                        counter   <= CW'(N - 1);
                        if (b_zero_in) begin
                            quotient_reg <= {div_if.a_in[W-1] ^ div_if.b_in[W-1], {M{1'b1}}};
                            overflow_reg <= 1'b1;
                            dbz_reg      <= 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    dividend  <= {dividend[N-2:0], 1'b0};
                    remainder <= rem_step;
                    quotient  <= quot_step;
                    counter   <= counter - 1'b1;
                    if (counter == '0) begin
                        quotient_reg <= result_step[W-1:0];
                        overflow_reg <= result_step[W];
                        dbz_reg      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_if.quotient_out    = quotient_reg;
    assign div_if.overflow_out    = overflow_reg;
    assign div_if.div_by_zero_out = dbz_reg;
endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed-vector bench for fixed_point_divider. An arithmetic reference model queues the
// expected results. A negedge compare process then checks every valid output cycle against that queue.
module tb_fixed_point_divider;
    localparam int N = 46;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    typedef struct {
        logic [33:0] res;
        int          first;
        bit          seen;
    } exp_t;
    exp_t expq[$];

    fixed_point_divider_if #(.W(32)) bus ();

    fixed_point_divider dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .div_if   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference result packed as {div_by_zero, overflow, quotient}.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] num;
        logic [63:0] qv;
        logic [30:0] mag;
        logic        s;
        s = a[31] ^ b[31];
        if (b[30:0] == 31'd0)
            return {1'b1, 1'b1, s, 31'h7FFFFFFF};
        num = 64'(a[30:0]) << 15;
        qv  = num / 64'(b[30:0]);
        if (qv > 64'h7FFFFFFF)
            return {1'b0, 1'b1, s, 31'h7FFFFFFF};
        mag = qv[30:0];
        return {1'b0, 1'b0, s && (mag != 31'd0), mag};
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.valid_out) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid: got valid_out=1 q=0x%0h required no output", bus.quotient_out);
            end else begin
                if (!expq[0].seen) begin
                    check("latency_edge", 64'(cyc), 64'(expq[0].first));
                    expq[0].seen = 1'b1;
                end
                check("result", {30'd0, bus.div_by_zero_out, bus.overflow_out, bus.quotient_out},
                      {30'd0, expq[0].res});
                if (bus.ready_in) void'(expq.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lq,
                        input logic lo, input logic ld);
        exp_t        e;
        logic [33:0] m;
        int          guard;
        m = model(a, b);
        check("model_pin", {30'd0, m}, {30'd0, ld, lo, lq});
        @(posedge clk); #1;
        bus.a_in = a;
        bus.b_in = b;
        bus.valid_in = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            if (bus.ready_out) break;
            guard++;
            if (guard > 200) break;
        end
        if (guard > 200) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got ready_out=0 required 1");
        end else begin
            e.res   = m;
            e.first = cyc + 1 + (m[33] ? 0 : N);
            e.seen  = 1'b0;
            expq.push_back(e);
        end
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        bus.a_in = $urandom;
        bus.b_in = $urandom;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (expq.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (expq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL result_timeout: got %0d pending required 0", expq.size());
            expq.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.a_in = '0;
        bus.b_in = '0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        #23;
        check("rst_ready", 64'(bus.ready_out), 64'd1);
        check("rst_valid", 64'(bus.valid_out), 64'd0);
        check("rst_outs", {32'd0, bus.quotient_out}, 64'd0);
        check("rst_flags", {62'd0, bus.overflow_out, bus.div_by_zero_out}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        send(32'h00030000, 32'h00010000, 32'h00018000, 1'b0, 1'b0); wait_idle();
        send(32'h8000C000, 32'h00004000, 32'h80018000, 1'b0, 1'b0); wait_idle();
        send(32'h8000C000, 32'h80004000, 32'h00018000, 1'b0, 1'b0); wait_idle();
        send(32'h80010000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1); wait_idle();
        send(32'h40000000, 32'h00004000, 32'h7FFFFFFF, 1'b1, 1'b0); wait_idle();
        send(32'h80000000, 32'h80008000, 32'h00000000, 1'b0, 1'b0); wait_idle();
        send(32'h00000001, 32'h00010000, 32'h00000000, 1'b0, 1'b0); wait_idle();
        send(32'h00008000, 32'h00018000, 32'h00002AAA, 1'b0, 1'b0); wait_idle();
        send(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00008000, 1'b0, 1'b0); wait_idle();
        send(32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1); wait_idle();

        // Backpressure: result must hold while ready_in is low and stray valid_in is ignored
        bus.ready_in = 1'b0;
        send(32'h00030000, 32'h00010000, 32'h00018000, 1'b0, 1'b0);
        for (int g = 0; g < 100 && !bus.valid_out; g++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.valid_in = i[0];
            bus.a_in = $urandom;
            bus.b_in = $urandom;
            @(negedge clk);
            check("bp_ready_low", 64'(bus.ready_out), 64'd0);
            check("bp_valid_held", 64'(bus.valid_out), 64'd1);
        end
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_hs_valid", 64'(bus.valid_out), 64'd0);
        check("post_hs_ready", 64'(bus.ready_out), 64'd1);
        send(32'h00008000, 32'h00018000, 32'h00002AAA, 1'b0, 1'b0); wait_idle();

        // Reset in the middle of a division abandons it
        send(32'h00030000, 32'h00010000, 32'h00018000, 1'b0, 1'b0);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expq.delete();
        check("midrst_valid", 64'(bus.valid_out), 64'd0);
        check("midrst_ready", 64'(bus.ready_out), 64'd1);
        check("midrst_q", {32'd0, bus.quotient_out}, 64'd0);
        check("midrst_flags", {62'd0, bus.overflow_out, bus.div_by_zero_out}, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        send(32'h00030000, 32'h00010000, 32'h00018000, 1'b0, 1'b0); wait_idle();
        repeat (60) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Sequential sign-magnitude fixed-point divider: quotient_out = a_in / b_in, in the same sign/Q(q_m).(q_n) word format used by the perceptron datapath adders.
- Restoring shift-subtract algorithm, one quotient bit per clock.
- Used for normalisation and learning-rate scaling in the perceptron.
- Valid/ready handshake on both sides; one division in flight.

Parameters:
- sign, 1, sign bit count. Fixed at 1; MSB is the sign, the remaining bits are the magnitude.
- q_m, 16, integer magnitude bits.
- q_n, 15, fractional bits.
- Derived: W = sign+q_m+q_n (32); M = W-1 (31), magnitude width; N = M+q_n (46), iteration count.

Ports:
- clk_in, input, 1: clock, rising edge.
- rst_n_in, input, 1: reset, asynchronous, active-low. Single clock domain.
- a_in, input, W: dividend, sign-magnitude.
- b_in, input, W: divisor, sign-magnitude.
- valid_in, input, 1: operands valid.
- ready_out, output, 1: divider can accept operands.
- quotient_out, output, W: result, sign-magnitude.
- overflow_out, output, 1: result saturated because the magnitude exceeded M bits, or on divide-by-zero.
- div_by_zero_out, output, 1: b_in magnitude was zero.
- valid_out, output, 1: result valid.
- ready_in, input, 1: downstream accepts the result.

Behaviour:
- Reset (async assert, sync release): state=IDLE; ready_out=1; valid_out=0; quotient_out=0; overflow_out=0; div_by_zero_out=0. All internal registers are cleared. Reset mid-division abandons the operation and produces no output.
- FSM states: IDLE, DIVIDE, DONE.
- IDLE:
  - ready_out=1.
  - On valid_in&&ready_out, capture a_mag, b_mag, and sign_q=a_sign^b_sign.
  - If b_mag==0, go to DONE next cycle with div-by-zero result.
  - Otherwise go to DIVIDE, with dividend = {a_mag, q_n zeros} (N bits), remainder=0, counter=N-1.
- DIVIDE:
  - ready_out=0.
  - Each cycle: remainder = {remainder, next dividend MSB}. If remainder >= b_mag, subtract b_mag and set the quotient bit to 1; else the bit is 0.
  - Exactly N cycles. After the counter reaches 0, go to DONE.
  - Remainder is M+1 bits wide so the compare never overflows.
- Result formation on entry to DONE, all outputs registered:
  - Quotient magnitude Q is N bits, truncated toward zero with no rounding.
  - If Q[N-1:M] != 0: magnitude = all ones, overflow_out=1.
  - Divide-by-zero: magnitude = all ones, overflow_out=1, div_by_zero_out=1.
  - Sign: sign_q. When the final magnitude is zero, sign is forced to 0; no negative zero is ever output.
  - Inputs of -0 are treated as magnitude 0.
- DONE:
  - valid_out=1; ready_out=0.
  - quotient_out and both flags are held stable while valid_out&&!ready_in.
  - On valid_out&&ready_in, go to IDLE next cycle and drop valid_out.
  - No same-cycle accept of new operands; ready_out rises the cycle after the output handshake.
- Latency, counted from the accept edge:
  - Normal: valid_out is high after N+1 rising edges (47 for the defaults).
  - Divide-by-zero: valid_out is high after 1 edge.
- Throughput: one result per N+2 cycles minimum.
- valid_in while ready_out=0 is ignored. Operands are sampled only on accept; later changes on a_in/b_in have no effect.

Test Plan:
- 6.0/2.0: a_in=0x00030000, b_in=0x00010000 → quotient_out=0x00018000, flags 0, valid_out exactly 47 edges after accept.
- -1.5/0.5: a_in=0x8000C000, b_in=0x00004000 → 0x80018000. Then -1.5/-0.5 (b_in=0x80004000) → 0x00018000.
- Divide-by-zero: a_in=0x80010000, b_in=0x00000000 → 0xFFFFFFFF, overflow_out=1, div_by_zero_out=1, valid_out 1 edge after accept. Overflow: a_in=0x40000000, b_in=0x00004000 → 0x7FFFFFFF, overflow_out=1, div_by_zero_out=0.
- Zero/sign/truncation:
  - a_in=0x80000000 (-0), b_in=0x80008000 → 0x00000000.
  - a_in=0x00000001, b_in=0x00010000 → 0x00000000 (truncated), sign 0.
  - 1.0/3.0 → 0x00002AAA.
- Backpressure: hold ready_in=0 for 10 cycles in DONE → quotient_out/valid_out stable, ready_out=0, valid_in pulses ignored. Then ready_in=1 → valid_out=0 and ready_out=1 next cycle; back-to-back second division correct.
- Reset mid-op: deassert rst_n_in at DIVIDE cycle 20 → outputs immediately take reset values. After release, a new 6.0/2.0 yields 0x00018000 with no stale result.
